// File: rtl/pzcorebus_response_pipeline_slicer_if.sv
// Valid/ready handshake bundle carrying one packed pzcorebus response beat.
interface pzcorebus_response_pipeline_slicer_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pzcorebus_response_pipeline_slicer.sv
// N-stage register slicer for the pzcorebus response channel (skid or half-rate stages).
// Optional synchronous flush is compiled in with PZCOREBUS_RESPONSE_SLICER_FLUSH_EN.
module pzcorebus_response_pipeline_slicer #(
  parameter int WIDTH          = 32,
  parameter int STAGES         = 2,
  parameter bit FULL_BANDWIDTH = 1'b1,
  parameter bit USE_RESET      = 1'b1,
  parameter int OCC_W          = ((STAGES * (FULL_BANDWIDTH ? 2 : 1)) < 1) ? 1 :
                                 $clog2(STAGES * (FULL_BANDWIDTH ? 2 : 1) + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_flush,
  pzcorebus_response_pipeline_slicer_if.slave  i_up,
  pzcorebus_response_pipeline_slicer_if.master o_dn,
  output logic [OCC_W-1:0]                     o_occupancy
);

  logic w_flush;
`ifdef PZCOREBUS_RESPONSE_SLICER_FLUSH_EN
  assign w_flush = i_flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_flush        = 1'b0;
`endif

  if (STAGES == 0) begin : g_bypass
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_clk, i_rst, w_flush};
    assign o_dn.valid  = i_up.valid;
    assign o_dn.data   = i_up.data;
    assign i_up.ready  = o_dn.ready;
    assign o_occupancy = '0;
  end else begin : g_pipe
    // Index k of the chain is the input of stage k and the output of stage k-1.
    logic             w_valid [0:STAGES];
    logic             w_ready [0:STAGES];
    logic [WIDTH-1:0] w_data  [0:STAGES];
    logic [1:0]       w_occ   [0:STAGES-1];

    assign w_valid[0]      = i_up.valid & ~w_flush;
    assign w_data[0]       = i_up.data;
    assign i_up.ready      = w_ready[0] & ~w_flush;
    assign o_dn.valid      = w_valid[STAGES] & ~w_flush;
    assign o_dn.data       = w_data[STAGES];
    assign w_ready[STAGES] = o_dn.ready & ~w_flush;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (FULL_BANDWIDTH) begin : g_full
        logic             r_main_valid;
        logic             r_skid_valid;
        logic [WIDTH-1:0] r_main_data;
        logic [WIDTH-1:0] r_skid_data;
        logic             w_in_fire;
        logic             w_main_load;
        logic             w_main_dload;
        logic             w_skid_load;
        logic [WIDTH-1:0] w_main_next;

        // Main refills whenever it is empty or being drained; the skid only
        // catches a beat that arrives while main is stalled.
        assign w_in_fire    = w_valid[gi] & ~r_skid_valid;
        assign w_main_load  = ~r_main_valid | w_ready[gi+1];
        assign w_main_dload = w_main_load & (r_skid_valid | w_in_fire);
        assign w_skid_load  = w_in_fire & ~w_main_load;
        assign w_main_next  = r_skid_valid ? r_skid_data : w_data[gi];

        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
          end else if (w_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
          end else if (w_main_load) begin
            r_main_valid <= r_skid_valid | w_in_fire;
            r_skid_valid <= 1'b0;
          end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
          end
        end

        if (USE_RESET) begin : g_data_rst
          always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
              r_main_data <= '0;
              r_skid_data <= '0;
            end else begin
              if (w_main_dload) r_main_data <= w_main_next;
              if (w_skid_load)  r_skid_data <= w_data[gi];
            end
          end
        end else begin : g_data_norst
          always_ff @(posedge i_clk) begin
            if (w_main_dload) r_main_data <= w_main_next;
            if (w_skid_load)  r_skid_data <= w_data[gi];
          end
        end

        assign w_ready[gi]   = ~r_skid_valid;
        assign w_valid[gi+1] = r_main_valid;
        assign w_data[gi+1]  = r_main_data;
        assign w_occ[gi]     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
      end else begin : g_half
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             w_in_fire;

        assign w_in_fire = w_valid[gi] & ~r_valid;

        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_valid <= 1'b0;
          end else if (w_flush) begin
            r_valid <= 1'b0;
          end else if (w_in_fire) begin
            r_valid <= 1'b1;
          end else if (w_ready[gi+1]) begin
            r_valid <= 1'b0;
          end
        end

        if (USE_RESET) begin : g_data_rst
          always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)          r_data <= '0;
            else if (w_in_fire) r_data <= w_data[gi];
          end
        end else begin : g_data_norst
          always_ff @(posedge i_clk) begin
            if (w_in_fire) r_data <= w_data[gi];
          end
        end

        assign w_ready[gi]   = ~r_valid;
        assign w_valid[gi+1] = r_valid;
        assign w_data[gi+1]  = r_data;
        assign w_occ[gi]     = {1'b0, r_valid};
      end
    end

    always_comb begin
      o_occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
        o_occupancy = o_occupancy + OCC_W'(w_occ[k]);
      end
    end
  end

endmodule

// File: tb/tb_pzcorebus_response_pipeline_slicer.sv
// Bench for the response slicer: three instances (2-stage full-bw, 3-stage half-rate,
// bypass) checked every cycle against per-stage FIFO models plus literal expectations.
`timescale 1ns/1ps
module tb_pzcorebus_response_pipeline_slicer;
`ifdef PZCOREBUS_RESPONSE_SLICER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  pzcorebus_response_pipeline_slicer_if #(.WIDTH(8)) a_up(), a_dn(), b_up(), b_dn(), c_up(), c_dn();
  logic [2:0] a_occ;
  logic [1:0] b_occ;
  logic [0:0] c_occ;

  pzcorebus_response_pipeline_slicer #(.WIDTH(8), .STAGES(2), .FULL_BANDWIDTH(1'b1), .USE_RESET(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up(a_up), .o_dn(a_dn), .o_occupancy(a_occ));
  pzcorebus_response_pipeline_slicer #(.WIDTH(8), .STAGES(3), .FULL_BANDWIDTH(1'b0), .USE_RESET(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up(b_up), .o_dn(b_dn), .o_occupancy(b_occ));
  pzcorebus_response_pipeline_slicer #(.WIDTH(8), .STAGES(0), .FULL_BANDWIDTH(1'b1), .USE_RESET(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_up(c_up), .o_dn(c_dn), .o_occupancy(c_occ));

  // Model: each stage is a small FIFO (capacity 2 or 1); a beat hops when the
  // next FIFO had room before the edge.
  logic [7:0] ent [2][3][2];
  int         cnt [2][3];
  int         cap [2];
  int         nst [2];
  bit         acc_f [2];
  bit         emit_f [2];
  logic [7:0] emit_d [2];
  int         emit_cnt [2];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         seq_on = 1'b0;
  int         seq_next = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) cnt[d][k] = 0;
      emit_f[d] = 1'b0;
      acc_f[d]  = 1'b0;
    end
  endtask

  function automatic int m_occ(int d);
    int s = 0;
    for (int k = 0; k < nst[d]; k++) s += cnt[d][k];
    return s;
  endfunction

  function automatic bit m_ovalid(int d);
    return !(FLUSH_EN && flush) && (cnt[d][nst[d]-1] > 0);
  endfunction

  function automatic bit m_oready(int d);
    return !(FLUSH_EN && flush) && (cnt[d][0] < cap[d]);
  endfunction

  task automatic m_step(int d, bit v, bit r, logic [7:0] din);
    bit         mv [3];
    bit         acc;
    logic [7:0] head;
    int         n = nst[d];
    acc_f[d]  = 1'b0;
    emit_f[d] = 1'b0;
    if (FLUSH_EN && flush) begin
      for (int k = 0; k < 3; k++) cnt[d][k] = 0;
      return;
    end
    acc = v && (cnt[d][0] < cap[d]);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) mv[k] = (cnt[d][k] > 0) && r;
      else            mv[k] = (cnt[d][k] > 0) && (cnt[d][k+1] < cap[d]);
    end
    for (int k = n - 1; k >= 0; k--) begin
      if (mv[k]) begin
        head         = ent[d][k][0];
        ent[d][k][0] = ent[d][k][1];
        cnt[d][k]--;
        if (k == n - 1) begin
          emit_f[d] = 1'b1;
          emit_d[d] = head;
        end else begin
          ent[d][k+1][cnt[d][k+1]] = head;
          cnt[d][k+1]++;
        end
      end
    end
    if (acc) begin
      ent[d][0][cnt[d][0]] = din;
      cnt[d][0]++;
    end
    acc_f[d] = acc;
  endtask

  task automatic chk_dut(string tag, int d, logic v, logic r, logic [7:0] dat, int occ);
    chk({tag, "_valid"}, {31'd0, v}, {31'd0, m_ovalid(d)});
    chk({tag, "_ready"}, {31'd0, r}, {31'd0, m_oready(d)});
    chk({tag, "_occ"}, occ, m_occ(d));
    if (m_ovalid(d)) chk({tag, "_data"}, {24'd0, dat}, {24'd0, ent[d][nst[d]-1][0]});
  endtask

  task automatic tick();
    @(negedge clk);
    chk_dut("a", 0, a_dn.valid, a_up.ready, a_dn.data, int'(a_occ));
    chk_dut("b", 1, b_dn.valid, b_up.ready, b_dn.data, int'(b_occ));
    chk("c_valid", {31'd0, c_dn.valid}, {31'd0, c_up.valid});
    chk("c_ready", {31'd0, c_up.ready}, {31'd0, c_dn.ready});
    chk("c_data", {24'd0, c_dn.data}, {24'd0, c_up.data});
    chk("c_occ", {31'd0, c_occ}, 32'd0);
    if (seq_on && a_dn.valid && a_dn.ready) begin
      chk("t2_order", {24'd0, a_dn.data}, seq_next);
      seq_next++;
    end
    if (rst) m_clear();
    else begin
      m_step(0, a_up.valid, a_dn.ready, a_up.data);
      m_step(1, b_up.valid, b_dn.ready, b_up.data);
    end
    for (int d = 0; d < 2; d++) begin
      if (emit_f[d]) begin
        emit_cnt[d]++;
        $display("[%0t] dut%0d beat out %02h", $time, d, emit_d[d]);
      end
    end
    @(posedge clk);
    #1;
    c_up.valid = 1'($urandom);
    c_up.data  = 8'($urandom);
    c_dn.ready = 1'($urandom);
  endtask

  initial begin
    int beat;
    int ready_low;
    int accs;
    int e0;
    cap[0] = 2; nst[0] = 2;
    cap[1] = 1; nst[1] = 3;
    emit_cnt[0] = 0; emit_cnt[1] = 0;
    m_clear();
    rst = 1'b1; flush = 1'b0;
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_a_valid", {31'd0, a_dn.valid}, 32'd0);
    chk("rst_a_ready", {31'd0, a_up.ready}, 32'd1);
    chk("rst_a_occ", {29'd0, a_occ}, 32'd0);
    chk("rst_a_data", {24'd0, a_dn.data}, 32'd0);
    chk("rst_b_ready", {31'd0, b_up.ready}, 32'd1);
    chk("rst_b_occ", {30'd0, b_occ}, 32'd0);

    // 100 back-to-back beats through the full-bandwidth pipe
    a_dn.ready = 1'b1; beat = 0; ready_low = 0; seq_on = 1'b1; seq_next = 0;
    for (int c = 0; c < 110; c++) begin
      a_up.valid = (beat < 100);
      a_up.data  = 8'(beat);
      if (c == 1) chk("t2_lat_early", {31'd0, a_dn.valid}, 32'd0);
      if (c == 2) begin
        chk("t2_lat_valid", {31'd0, a_dn.valid}, 32'd1);
        chk("t2_lat_data", {24'd0, a_dn.data}, 32'd0);
      end
      if (beat < 100 && !a_up.ready) ready_low++;
      tick();
      if (acc_f[0]) beat++;
    end
    seq_on = 1'b0;
    chk("t2_ready_low", ready_low, 32'd0);
    chk("t2_count", seq_next, 32'd100);

    // Backpressure fills four entries, then drains in order
    a_dn.ready = 1'b0; a_up.valid = 1'b1; beat = 0;
    for (int c = 0; c < 6; c++) begin
      a_up.data = 8'h10 + 8'(beat);
      tick();
      if (acc_f[0]) beat++;
    end
    chk("t3_occ", {29'd0, a_occ}, 32'd4);
    chk("t3_ready", {31'd0, a_up.ready}, 32'd0);
    chk("t3_valid", {31'd0, a_dn.valid}, 32'd1);
    chk("t3_head", {24'd0, a_dn.data}, 32'h10);
    a_up.valid = 1'b0; a_dn.ready = 1'b1; e0 = emit_cnt[0];
    repeat (6) tick();
    chk("t3_drained", emit_cnt[0] - e0, 32'd4);

    // Half-rate pipe: one beat every two cycles, three-cycle latency
    b_dn.ready = 1'b1; b_up.valid = 1'b1; beat = 0; accs = 0;
    for (int c = 0; c < 20; c++) begin
      b_up.data = 8'h40 + 8'(beat);
      if (c == 2) chk("t4_lat_early", {31'd0, b_dn.valid}, 32'd0);
      if (c == 3) begin
        chk("t4_lat_valid", {31'd0, b_dn.valid}, 32'd1);
        chk("t4_lat_data", {24'd0, b_dn.data}, 32'h40);
      end
      tick();
      if (acc_f[1]) begin beat++; accs++; end
    end
    chk("t4_accepts", accs, 32'd10);
    b_up.valid = 1'b0;
    repeat (8) tick();

    // Asynchronous reset with three beats held
    a_dn.ready = 1'b0; a_up.valid = 1'b1; beat = 0;
    for (int c = 0; c < 3; c++) begin
      a_up.data = 8'h60 + 8'(beat);
      tick();
      if (acc_f[0]) beat++;
    end
    chk("t1_occ_before", {29'd0, a_occ}, 32'd3);
    #2;
    rst = 1'b1;
    m_clear();
    #1;
    chk("t1_valid", {31'd0, a_dn.valid}, 32'd0);
    chk("t1_occ", {29'd0, a_occ}, 32'd0);
    chk("t1_ready", {31'd0, a_up.ready}, 32'd1);
    a_up.valid = 1'b0;
    tick();
    rst = 1'b0;
    a_dn.ready = 1'b1; e0 = emit_cnt[0];
    repeat (5) tick();
    chk("t1_no_stale", emit_cnt[0] - e0, 32'd0);

`ifdef PZCOREBUS_RESPONSE_SLICER_FLUSH_EN
    a_dn.ready = 1'b0; a_up.valid = 1'b1; beat = 0;
    for (int c = 0; c < 3; c++) begin
      a_up.data = 8'h20 + 8'(beat);
      tick();
      if (acc_f[0]) beat++;
    end
    chk("t5_occ_before", {29'd0, a_occ}, 32'd3);
    flush = 1'b1; a_dn.ready = 1'b1;
    #1;
    chk("t5_ready_flush", {31'd0, a_up.ready}, 32'd0);
    chk("t5_valid_flush", {31'd0, a_dn.valid}, 32'd0);
    tick();
    flush = 1'b0;
    chk("t5_occ_after", {29'd0, a_occ}, 32'd0);
    a_up.data = 8'hA5;
    tick();
    a_up.valid = 1'b0;
    tick();
    chk("t5_valid", {31'd0, a_dn.valid}, 32'd1);
    chk("t5_data", {24'd0, a_dn.data}, 32'hA5);
    repeat (3) tick();
`endif

    // Random traffic on both registered pipes
    for (int c = 0; c < 1500; c++) begin
      a_up.valid = ($urandom_range(0, 3) != 0);
      a_up.data  = 8'($urandom);
      a_dn.ready = ($urandom_range(0, 2) != 0);
      b_up.valid = ($urandom_range(0, 3) != 0);
      b_up.data  = 8'($urandom);
      b_dn.ready = ($urandom_range(0, 2) != 0);
      if (FLUSH_EN) flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
